// File: rtl/dtim_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// dtim_port_arbiter_if.sv
// Bus bundles used by dtim_port_arbiter.
//
//   dtim_arb_req_if : requester-side port (core / DMA-debug <-> arbiter)
//     valid, addr[31:0], wdata[31:0], wstrb[3:0]  requester -> arbiter
//     ready, rdata[31:0], err                     arbiter   -> requester
//     modport master : the requester
//     modport slave  : the arbiter
//
//   dtim_arb_mem_if : memory-side port (arbiter <-> dtim)
//     valid, addr[31:0], wdata[31:0], wstrb[3:0]  arbiter -> dtim
//     ready, rdata[31:0]                          dtim    -> arbiter
//     modport master : the arbiter
//     modport slave  : dtim
// -----------------------------------------------------------------------------
interface dtim_arb_req_if;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;
    logic        err;

    modport master (output valid, addr, wdata, wstrb, input  ready, rdata, err);
    modport slave  (input  valid, addr, wdata, wstrb, output ready, rdata, err);
endinterface

interface dtim_arb_mem_if;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (output valid, addr, wdata, wstrb, input  ready, rdata);
    modport slave  (input  valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/dtim_port_arbiter.sv
// -----------------------------------------------------------------------------
// dtim_port_arbiter
// Shares the single dtim request port between the core data port (m0) and the
// DMA/debug port (m1). One transaction in flight; the winning request is
// latched and held on s until dtim answers or the watchdog aborts it.
//
// Ports
//   clk  in  clock, all state on rising edge
//   rst  in  asynchronous active-low reset
//   m0   dtim_arb_req_if.slave   core requester
//   m1   dtim_arb_req_if.slave   DMA/debug requester
//   s    dtim_arb_mem_if.master  request port to dtim
//
// Parameters
//   TIMEOUT_CYCLES  BUSY cycles without s.ready before abort (0 = no watchdog)
//   CNT_WIDTH       watchdog counter width, 2**CNT_WIDTH > TIMEOUT_CYCLES
//
// Configuration macro
//   DTIM_ARB_RR_EN  defined: round-robin on ties; undefined: m0 fixed priority
// -----------------------------------------------------------------------------
module dtim_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_WIDTH      = 9
) (
    input  logic            clk,
    input  logic            rst,
    dtim_arb_req_if.slave   m0,
    dtim_arb_req_if.slave   m1,
    dtim_arb_mem_if.master  s
);

    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_e;

    state_e               state_q, state_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [3:0]           wstrb_q, wstrb_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 last_q, last_d;    // 1 = last grant went to m1

    logic busy;
    logic any_req;
    logic pick_m1;
    logic expire;

    assign busy    = (state_q != IDLE);
    assign any_req = m0.valid | m1.valid;

`ifdef DTIM_ARB_RR_EN
    // On a tie the master that did not win last time gets the grant.
    assign pick_m1 = m1.valid & (~m0.valid | ~last_q);
`else
    assign pick_m1 = m1.valid & ~m0.valid;
`endif

    // Expiry is the TIMEOUT_CYCLES-th unanswered BUSY cycle; a response
    // arriving in that same cycle takes precedence.
    always_comb begin
        expire = 1'b0;
        if (TIMEOUT_CYCLES != 0) begin
            expire = busy && !s.ready &&
                     (cnt_q >= CNT_WIDTH'(TIMEOUT_CYCLES - 1));
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (any_req) begin
                    state_d = pick_m1 ? BUSY1 : BUSY0;
                    addr_d  = pick_m1 ? m1.addr  : m0.addr;
                    wdata_d = pick_m1 ? m1.wdata : m0.wdata;
                    wstrb_d = pick_m1 ? m1.wstrb : m0.wstrb;
                    last_d  = pick_m1;
                end
            end
            BUSY0, BUSY1: begin
                if (s.ready || expire) begin
                    state_d = IDLE;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q != '1)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        s.valid  = busy;
        s.addr   = addr_q;
        s.wdata  = wdata_q;
        s.wstrb  = wstrb_q;

        m0.ready = (state_q == BUSY0) && (s.ready || expire);
        m0.rdata = ((state_q == BUSY0) && s.ready) ? s.rdata : '0;
        m0.err   = (state_q == BUSY0) && expire;

        m1.ready = (state_q == BUSY1) && (s.ready || expire);
        m1.rdata = ((state_q == BUSY1) && s.ready) ? s.rdata : '0;
        m1.err   = (state_q == BUSY1) && expire;
    end

endmodule

// File: tb/tb_dtim_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dtim_port_arbiter
// Scoreboarded bench for dtim_port_arbiter (TIMEOUT_CYCLES=8). Expected
// transactions are queued in grant order when stimulus is issued; a negedge
// monitor checks s_* against the queue head and pops on each m*_ready.
// A behavioural dtim answers after a programmable latency or stays silent.
// -----------------------------------------------------------------------------
module tb_dtim_port_arbiter;

    localparam int unsigned TMO = 8;

    typedef struct {
        int          m;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;

    dtim_arb_req_if m0_bus ();
    dtim_arb_req_if m1_bus ();
    dtim_arb_mem_if s_bus ();

    dtim_port_arbiter #(.TIMEOUT_CYCLES(TMO), .CNT_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .m0  (m0_bus),
        .m1  (m1_bus),
        .s   (s_bus)
    );

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    exp_t mon_e;
    int   busy_cnt = 0;
    bit   prev_rdy = 0;
    int   slv_lat  = 0;
    bit   slv_mute = 0;
    int   scnt     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return (a == 32'h40) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0F0F);
    endfunction

    task automatic push_exp(input int m, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] st, input bit tmo, input int lat);
        exp_t e;
        e.m     = m;
        e.addr  = a;
        e.wdata = d;
        e.wstrb = st;
        e.rdata = tmo ? 32'h0 : rd_of(a);
        e.err   = tmo;
        e.cyc   = tmo ? int'(TMO) : lat + 1;
        q.push_back(e);
    endtask

    // Call just after a rising edge. Holds the request until ready, then
    // drops valid just after the next edge (a follow-up call may re-raise it).
    task automatic drive(input int m, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] st);
        int n;
        bit got;
        if (m == 0) begin
            m0_bus.valid = 1'b1; m0_bus.addr = a; m0_bus.wdata = d; m0_bus.wstrb = st;
        end else begin
            m1_bus.valid = 1'b1; m1_bus.addr = a; m1_bus.wdata = d; m1_bus.wstrb = st;
        end
        n   = 0;
        got = 0;
        while (!got && n < 300) begin
            @(negedge clk);
            n++;
            got = (m == 0) ? m0_bus.ready : m1_bus.ready;
        end
        if (!got) check_eq("req_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (m == 0) begin
            m0_bus.valid = 1'b0; m0_bus.addr = '0; m0_bus.wdata = '0; m0_bus.wstrb = '0;
        end else begin
            m1_bus.valid = 1'b0; m1_bus.addr = '0; m1_bus.wdata = '0; m1_bus.wstrb = '0;
        end
    endtask

    // Behavioural dtim: ready slv_lat cycles after s.valid rises, junk rdata otherwise.
    initial begin
        s_bus.ready = 1'b0;
        s_bus.rdata = 32'hBAD0_0000;
        forever begin
            @(posedge clk);
            #1;
            if (s_bus.ready) begin
                s_bus.ready = 1'b0;
                scnt        = 0;
            end else if (s_bus.valid && !slv_mute) begin
                if (scnt == slv_lat) s_bus.ready = 1'b1;
                else scnt++;
            end else begin
                scnt = 0;
            end
            s_bus.rdata = s_bus.ready ? rd_of(s_bus.addr) : (32'hBAD0_0000 | 32'(scnt));
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            busy_cnt = 0;
            prev_rdy = 0;
        end else begin
            if (prev_rdy) check_eq("bubble_svalid", 32'(s_bus.valid), 32'd0);
            if (s_bus.valid) begin
                busy_cnt++;
                if (q.size() == 0) begin
                    check_eq("unexp_svalid", 32'd1, 32'd0);
                end else begin
                    check_eq("s_addr",  s_bus.addr,         q[0].addr);
                    check_eq("s_wdata", s_bus.wdata,        q[0].wdata);
                    check_eq("s_wstrb", 32'(s_bus.wstrb),   32'(q[0].wstrb));
                end
            end
            if (m0_bus.ready || m1_bus.ready) begin
                if (m0_bus.ready && m1_bus.ready) check_eq("both_ready", 32'd1, 32'd0);
                if (q.size() == 0) begin
                    check_eq("unexp_ready", 32'd1, 32'd0);
                end else begin
                    mon_e = q.pop_front();
                    check_eq("grant",   32'(m1_bus.ready), 32'(mon_e.m));
                    check_eq("rdata",   m1_bus.ready ? m1_bus.rdata : m0_bus.rdata, mon_e.rdata);
                    check_eq("err",     32'(m1_bus.ready ? m1_bus.err : m0_bus.err), 32'(mon_e.err));
                    check_eq("latency", 32'(busy_cnt), 32'(mon_e.cyc));
                    check_eq("loser_quiet",
                             m1_bus.ready ? (m0_bus.rdata | 32'(m0_bus.err))
                                          : (m1_bus.rdata | 32'(m1_bus.err)), 32'd0);
                end
                prev_rdy = 1;
                busy_cnt = 0;
            end else begin
                prev_rdy = 0;
                check_eq("idle_rdata", m0_bus.rdata | m1_bus.rdata, 32'd0);
                check_eq("idle_err",   32'({m0_bus.err, m1_bus.err}), 32'd0);
            end
            if (!s_bus.valid) busy_cnt = 0;
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout bench did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        rst = 1'b0;
        m0_bus.valid = 1'b1; m0_bus.addr = 32'h10; m0_bus.wdata = 32'h11; m0_bus.wstrb = 4'h3;
        m1_bus.valid = 1'b1; m1_bus.addr = 32'h20; m1_bus.wdata = 32'h21; m1_bus.wstrb = 4'hC;

        // Reset with both requesters active: everything quiet.
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_svalid", 32'(s_bus.valid), 32'd0);
            check_eq("rst_saddr",  s_bus.addr,  32'd0);
            check_eq("rst_swdata", s_bus.wdata, 32'd0);
            check_eq("rst_swstrb", 32'(s_bus.wstrb), 32'd0);
            check_eq("rst_mready", 32'({m0_bus.ready, m1_bus.ready}), 32'd0);
            check_eq("rst_mrdata", m0_bus.rdata | m1_bus.rdata, 32'd0);
            check_eq("rst_merr",   32'({m0_bus.err, m1_bus.err}), 32'd0);
        end
        slv_lat = 1;
        push_exp(0, 32'h10, 32'h11, 4'h3, 0, 1);
        push_exp(1, 32'h20, 32'h21, 4'hC, 0, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("grant_after_rst", 32'(s_bus.valid), 32'd1);
        fork
            drive(0, 32'h10, 32'h11, 4'h3);
            drive(1, 32'h20, 32'h21, 4'hC);
        join

        // m0 read, dtim answers 3 cycles after s.valid.
        slv_lat = 3;
        push_exp(0, 32'h40, 32'h0, 4'h0, 0, 3);
        drive(0, 32'h40, 32'h0, 4'h0);

        // Four requests from each master, all contending.
        slv_lat = 0;
`ifdef DTIM_ARB_RR_EN
        for (int i = 0; i < 4; i++) begin
            push_exp(0, 32'h1000 + 32'(i * 4), 32'hA000 + 32'(i), 4'hF, 0, 0);
            push_exp(1, 32'h2000 + 32'(i * 4), 32'hB000 + 32'(i), 4'h1, 0, 0);
        end
`else
        for (int i = 0; i < 4; i++)
            push_exp(0, 32'h1000 + 32'(i * 4), 32'hA000 + 32'(i), 4'hF, 0, 0);
        for (int i = 0; i < 4; i++)
            push_exp(1, 32'h2000 + 32'(i * 4), 32'hB000 + 32'(i), 4'h1, 0, 0);
`endif
        fork
            for (int i = 0; i < 4; i++) drive(0, 32'h1000 + 32'(i * 4), 32'hA000 + 32'(i), 4'hF);
            for (int j = 0; j < 4; j++) drive(1, 32'h2000 + 32'(j * 4), 32'hB000 + 32'(j), 4'h1);
        join

        // m1 write in flight; m0 arrives mid-transaction and must wait.
        slv_lat = 4;
        push_exp(1, 32'h100, 32'h1234_5678, 4'hF, 0, 4);
        push_exp(0, 32'h200, 32'h0000_CAFE, 4'h3, 0, 4);
        fork
            drive(1, 32'h100, 32'h1234_5678, 4'hF);
            begin
                repeat (2) @(posedge clk);
                #1;
                drive(0, 32'h200, 32'h0000_CAFE, 4'h3);
            end
        join

        // Watchdog abort: dtim never answers.
        slv_mute = 1;
        push_exp(0, 32'h300, 32'h0, 4'h0, 1, 0);
        drive(0, 32'h300, 32'h0, 4'h0);
        check_eq("abort_svalid", 32'(s_bus.valid), 32'd0);
        slv_mute = 0;

        // Response in the expiry cycle beats the abort.
        slv_lat = int'(TMO) - 1;
        push_exp(0, 32'h304, 32'h0, 4'h0, 0, int'(TMO) - 1);
        drive(0, 32'h304, 32'h0, 4'h0);

        // One cycle before expiry on m1.
        slv_lat = int'(TMO) - 2;
        push_exp(1, 32'h308, 32'h55, 4'h2, 0, int'(TMO) - 2);
        drive(1, 32'h308, 32'h55, 4'h2);

        // Reset in the middle of a BUSY1 transaction.
        slv_mute = 1;
        push_exp(1, 32'h400, 32'h77, 4'hF, 0, 0);
        m1_bus.valid = 1'b1; m1_bus.addr = 32'h400; m1_bus.wdata = 32'h77; m1_bus.wstrb = 4'hF;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_eq("midrst_svalid", 32'(s_bus.valid), 32'd0);
        check_eq("midrst_mready", 32'(m1_bus.ready), 32'd0);
        q.delete();
        m1_bus.valid = 1'b0; m1_bus.addr = '0; m1_bus.wdata = '0; m1_bus.wstrb = '0;
        @(negedge clk);
        rst = 1'b1;
        slv_mute = 0;
        repeat (10) begin
            @(negedge clk);
            check_eq("post_rst_no_ready", 32'(m1_bus.ready), 32'd0);
        end

        // Normal service resumes.
        slv_lat = 2;
        push_exp(1, 32'h500, 32'h99, 4'h8, 0, 2);
        @(posedge clk);
        #1;
        drive(1, 32'h500, 32'h99, 4'h8);

        repeat (4) @(negedge clk);
        check_eq("sb_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
